exec_stage: RTL and testbench
=============================

# exec_stage

Data-processing execute stage sitting directly downstream of the operand read stage. Accepts an already-shifted operand pair plus the decoded opcode/condition, evaluates the ARM condition code against the internal NZCV register, and performs the 16 data-processing operations. Registers one writeback result per accepted instruction behind a valid/ready handshake toward the writeback stage.

## Interface
- No parameters.
- clk  in  1  clock; all state updates on posedge.
- rst_n  in  1  reset, synchronous, active-low.
- in_valid  in  1  operand bundle valid.
- in_ready  out  1  stage can accept; `!wb_valid || wb_ready`.
- dp_dt  in  1  1 = data-processing instruction, 0 = other (passes as bubble).
- cond  in  4  ARM condition field.
- mf_op  in  6  [5]=I, [4:1]=opcode, [0]=S.
- reg_d  in  4  destination register.
- operand_1  in  32  Rn value.
- operand_2  in  32  shifted operand.
- wb_valid  out  1  result slot valid.
- wb_ready  in  1  writeback consumes slot.
- wb_en  out  1  register write required.
- wb_addr  out  4  destination register.
- wb_data  out  32  result.
- flags  out  4  NZCV, {N,Z,C,V}.
- cnt_exec, cnt_skip  out  16 each  perf counters (see Configuration).

## Operation
- Accept = in_valid && in_ready at posedge. Output slot loaded on accept; cleared (wb_valid←0) when wb_ready && !accept.
- Condition pass uses flags as registered before the accept edge: EQ Z, NE !Z, CS C, CC !C, MI N, PL !N, VS V, VC !V, HI C&!Z, LS !C|Z, GE N==V, LT N!=V, GT !Z&(N==V), LE Z|(N!=V), AL 1, NV (0xF) 0.
- Opcodes: 0 AND,1 EOR,2 SUB,3 RSB,4 ADD,5 ADC,6 SBC,7 RSC,8 TST,9 TEQ,A CMP,B CMN,C ORR,D MOV,E BIC,F MVN. Arithmetic in 33 bits; SBC = a−b−!C, RSC = b−a−!C.
- wb_en = dp_dt && pass && opcode∉{8..B}. wb_addr=reg_d, wb_data=result always loaded (also when wb_en=0).
- Flag update iff dp_dt && pass && (S || opcode∈{8..B}). N=res[31], Z=(res==0). Arithmetic: C=carry-out (subtract: C=NOT borrow), V=signed overflow. Logical/move: C,V unchanged.
- dp_dt=0 or condition fail: slot still loaded with wb_valid=1, wb_en=0, flags unchanged.

## Timing
- Latency 1: accept at edge k → wb_valid/wb_data valid after edge k; flags updated at the same edge k.
- Throughput 1/cycle while wb_ready=1. Back-to-back dependent flag use sees the previous instruction's flags.
- wb_valid=1 && wb_ready=0: in_ready=0, outputs and flags hold.
- Simultaneous wb_ready and new accept: slot replaced, wb_valid stays 1.
- Reset (rst_n=0 at edge, including mid-stall): wb_valid=0, wb_en=0, wb_addr=0, wb_data=0, flags=0, counters=0; pending slot discarded.
- in_valid=0 never changes flags.

## Configuration
- EXEC_PERF_CNT_EN defined: cnt_exec increments per accept with dp_dt && pass; cnt_skip increments per accept with dp_dt && !pass; both wrap 0xFFFF→0.
- Undefined: counters not built, cnt_exec=cnt_skip=0 constantly.

## Test plan
- Reset then ADD (op 4,S=1,AL) 0x7FFFFFFF+1, reg_d=3 → next cycle wb_en=1, wb_addr=3, wb_data=0x80000000, flags=N1 Z0 C0 V1.
- CMP (op A) 5,5 then MOVEQ 0x12 to r2 → flags Z=1,C=1; second result wb_en=1, wb_data=0x12; MOVNE same values → wb_en=0.
- SUB S=1 3−5 → wb_data=0xFFFFFFFE, N=1,C=0; following ADC 1+1 → wb_data=2.
- Hold wb_ready=0 with in_valid=1 for 3 cycles → in_ready=0, wb_data/flags stable; release → next instruction accepted same edge.
- Assert rst_n=0 during stalled slot → wb_valid=0, flags=0 next cycle.
- With EXEC_PERF_CNT_EN: 4 passing + 2 failing dp instructions + 1 dp_dt=0 → cnt_exec=4, cnt_skip=2.

Source files
------------

// File: rtl/exec_stage.sv
// Data-processing execute stage: ARM condition evaluation, 16-op ALU, NZCV flags
// and a one-entry writeback slot. Optional perf counters under EXEC_PERF_CNT_EN.
module exec_stage (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        dp_dt,
    input  logic [3:0]  cond,
    input  logic [5:0]  mf_op,
    input  logic [3:0]  reg_d,
    input  logic [31:0] operand_1,
    input  logic [31:0] operand_2,
    output logic        wb_valid,
    input  logic        wb_ready,
    output logic        wb_en,
    output logic [3:0]  wb_addr,
    output logic [31:0] wb_data,
    output logic [3:0]  flags,
    output logic [15:0] cnt_exec,
    output logic [15:0] cnt_skip
);
    localparam int unsigned DW = 32;
    localparam int unsigned CW = 16;

    logic          wb_valid_q, wb_valid_d;
    logic          wb_en_q, wb_en_d;
    logic [3:0]    wb_addr_q, wb_addr_d;
    logic [DW-1:0] wb_data_q, wb_data_d;
    logic [3:0]    flags_q, flags_d;

    logic          accept;
    logic [3:0]    opcode;
    logic          s_bit;
    logic          unused_i_bit;
    logic          flag_n, flag_z, flag_c, flag_v;
    logic          pass;
    logic          is_arith, is_cmp;
    logic [DW-1:0] x_op, y_op, result;
    logic          c_in;
    logic [DW:0]   sum;
    logic          arith_v;

    assign opcode       = mf_op[4:1];
    assign s_bit        = mf_op[0];
    assign unused_i_bit = mf_op[5];
    assign {flag_n, flag_z, flag_c, flag_v} = flags_q;
    assign in_ready     = !wb_valid_q || wb_ready;
    assign accept       = in_valid && in_ready;
    assign is_cmp       = (opcode[3:2] == 2'b10);

    // Condition evaluation against the flags held before this edge
    always_comb begin
        pass = 1'b0;
        case (cond)
            4'h0: pass = flag_z;
            4'h1: pass = !flag_z;
            4'h2: pass = flag_c;
            4'h3: pass = !flag_c;
            4'h4: pass = flag_n;
            4'h5: pass = !flag_n;
            4'h6: pass = flag_v;
            4'h7: pass = !flag_v;
            4'h8: pass = flag_c && !flag_z;
            4'h9: pass = !flag_c || flag_z;
            4'hA: pass = (flag_n == flag_v);
            4'hB: pass = (flag_n != flag_v);
            4'hC: pass = !flag_z && (flag_n == flag_v);
            4'hD: pass = flag_z || (flag_n != flag_v);
            4'hE: pass = 1'b1;
            default: pass = 1'b0;
        endcase
    end

    // Subtractions are done as x + ~y + cin so carry-out is NOT borrow
    always_comb begin
        is_arith = 1'b1;
        x_op     = operand_1;
        y_op     = operand_2;
        c_in     = 1'b0;
        case (opcode)
            4'h2, 4'hA: begin y_op = ~operand_2; c_in = 1'b1; end
            4'h3:       begin x_op = operand_2; y_op = ~operand_1; c_in = 1'b1; end
            4'h4, 4'hB: c_in = 1'b0;
            4'h5:       c_in = flag_c;
            4'h6:       begin y_op = ~operand_2; c_in = flag_c; end
            4'h7:       begin x_op = operand_2; y_op = ~operand_1; c_in = flag_c; end
            default:    is_arith = 1'b0;
        endcase
    end

    assign sum     = {1'b0, x_op} + {1'b0, y_op} + {{DW{1'b0}}, c_in};
    assign arith_v = (x_op[DW-1] == y_op[DW-1]) && (sum[DW-1] != x_op[DW-1]);

    always_comb begin
        result = sum[DW-1:0];
        case (opcode)
            4'h0, 4'h8: result = operand_1 & operand_2;
            4'h1, 4'h9: result = operand_1 ^ operand_2;
            4'hC:       result = operand_1 | operand_2;
            4'hD:       result = operand_2;
            4'hE:       result = operand_1 & ~operand_2;
            4'hF:       result = ~operand_2;
            default:    result = sum[DW-1:0];
        endcase
    end

    // Slot and flag next-state
    always_comb begin
        wb_valid_d = wb_valid_q;
        wb_en_d    = wb_en_q;
        wb_addr_d  = wb_addr_q;
        wb_data_d  = wb_data_q;
        flags_d    = flags_q;
        if (accept) begin
            wb_valid_d = 1'b1;
            wb_en_d    = dp_dt && pass && !is_cmp;
            wb_addr_d  = reg_d;
            wb_data_d  = result;
            if (dp_dt && pass && (s_bit || is_cmp)) begin
                flags_d[3] = result[DW-1];
                flags_d[2] = (result == '0);
                if (is_arith) begin
                    flags_d[1] = sum[DW];
                    flags_d[0] = arith_v;
                end
            end
        end else if (wb_ready) begin
            wb_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wb_valid_q <= 1'b0;
            wb_en_q    <= 1'b0;
            wb_addr_q  <= '0;
            wb_data_q  <= '0;
            flags_q    <= '0;
        end else begin
            wb_valid_q <= wb_valid_d;
            wb_en_q    <= wb_en_d;
            wb_addr_q  <= wb_addr_d;
            wb_data_q  <= wb_data_d;
            flags_q    <= flags_d;
        end
    end

    assign wb_valid = wb_valid_q;
    assign wb_en    = wb_en_q;
    assign wb_addr  = wb_addr_q;
    assign wb_data  = wb_data_q;
    assign flags    = flags_q;

`ifdef EXEC_PERF_CNT_EN
    logic [CW-1:0] cnt_exec_q, cnt_exec_d;
    logic [CW-1:0] cnt_skip_q, cnt_skip_d;

    always_comb begin
        cnt_exec_d = cnt_exec_q;
        cnt_skip_d = cnt_skip_q;
        if (accept && dp_dt) begin
            if (pass) cnt_exec_d = cnt_exec_q + CW'(1);
            else      cnt_skip_d = cnt_skip_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_exec_q <= '0;
            cnt_skip_q <= '0;
        end else begin
            cnt_exec_q <= cnt_exec_d;
            cnt_skip_q <= cnt_skip_d;
        end
    end

    assign cnt_exec = cnt_exec_q;
    assign cnt_skip = cnt_skip_q;
`else
    assign cnt_exec = '0;
    assign cnt_skip = '0;
`endif

endmodule

// File: tb/tb_exec_stage.sv
// Scoreboard bench for exec_stage: directed instructions push hand-computed results,
// a negedge monitor pops and compares whenever a slot is consumed.
module tb_exec_stage;
    logic        clk = 1'b0;
    logic        rst_n, in_valid, in_ready, dp_dt, wb_valid, wb_ready, wb_en;
    logic [3:0]  cond, reg_d, wb_addr, flags;
    logic [5:0]  mf_op;
    logic [31:0] operand_1, operand_2, wb_data;
    logic [15:0] cnt_exec, cnt_skip;

    typedef struct packed {
        logic        en;
        logic [3:0]  addr;
        logic [31:0] data;
        logic [3:0]  fl;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   exp_exec = 0;
    int   exp_skip = 0;

    exec_stage dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .dp_dt(dp_dt), .cond(cond), .mf_op(mf_op), .reg_d(reg_d),
        .operand_1(operand_1), .operand_2(operand_2), .wb_valid(wb_valid),
        .wb_ready(wb_ready), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .flags(flags), .cnt_exec(cnt_exec), .cnt_skip(cnt_skip)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Monitor: a slot is consumed exactly when wb_valid && wb_ready before an edge
    always @(negedge clk) begin
        if (rst_n && wb_valid && wb_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_slot actual=%h expected=none", wb_data);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("wb_en", 32'(wb_en), 32'(e.en));
                check("wb_addr", 32'(wb_addr), 32'(e.addr));
                check("wb_data", wb_data, e.data);
                check("flags", 32'(flags), 32'(e.fl));
            end
        end
    end

    task automatic issue(input logic dp, input logic [3:0] c, input logic [3:0] op,
                         input logic s, input logic [3:0] rd, input logic [31:0] a,
                         input logic [31:0] b, input logic ps, input logic e_en,
                         input logic [31:0] e_data, input logic [3:0] e_fl);
        exp_t e;
        logic rdy;
        int   budget;
        dp_dt = dp; cond = c; mf_op = {1'b0, op, s}; reg_d = rd;
        operand_1 = a; operand_2 = b; in_valid = 1'b1;
        e.en = e_en; e.addr = rd; e.data = e_data; e.fl = e_fl;
        sb.push_back(e);
        if (dp) begin
            if (ps) exp_exec++;
            else    exp_skip++;
        end
        budget = 0;
        do begin
            @(negedge clk);
            rdy = in_ready;
            @(posedge clk);
            budget++;
        end while (!rdy && budget < 20);
        if (!rdy) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout actual=0 expected=1");
        end
        #1 in_valid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; wb_ready = 1'b1; dp_dt = 1'b0;
        cond = '0; mf_op = '0; reg_d = '0; operand_1 = '0; operand_2 = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_wb_valid", 32'(wb_valid), 32'd0);
        check("rst_flags", 32'(flags), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1 rst_n = 1'b1;

        //    dp  cond  op    S   rd    op1           op2           pass en    data          NZCV
        issue(1, 4'hE, 4'h4, 1, 4'd3, 32'h7FFFFFFF, 32'h00000001, 1, 1, 32'h80000000, 4'b1001);
        issue(1, 4'hE, 4'hA, 1, 4'd0, 32'd5,        32'd5,        1, 0, 32'h00000000, 4'b0110);
        issue(1, 4'h0, 4'hD, 0, 4'd2, 32'd5,        32'h12,       1, 1, 32'h00000012, 4'b0110);
        issue(1, 4'h1, 4'hD, 0, 4'd2, 32'd5,        32'h12,       0, 0, 32'h00000012, 4'b0110);
        issue(1, 4'hE, 4'h2, 1, 4'd4, 32'd3,        32'd5,        1, 1, 32'hFFFFFFFE, 4'b1000);
        issue(1, 4'hE, 4'h5, 0, 4'd5, 32'd1,        32'd1,        1, 1, 32'h00000002, 4'b1000);
        issue(0, 4'hE, 4'h4, 1, 4'd6, 32'd7,        32'd8,        1, 0, 32'h0000000F, 4'b1000);
        issue(1, 4'hF, 4'h4, 1, 4'd1, 32'd1,        32'd1,        0, 0, 32'h00000002, 4'b1000);
        issue(1, 4'hE, 4'hB, 1, 4'd0, 32'hFFFFFFFF, 32'd1,        1, 0, 32'h00000000, 4'b0110);
        issue(1, 4'hE, 4'h1, 1, 4'd1, 32'hF0F0,     32'hFFFF,     1, 1, 32'h00000F0F, 4'b0010);
        issue(1, 4'hE, 4'h6, 1, 4'd1, 32'd10,       32'd3,        1, 1, 32'h00000007, 4'b0010);
        issue(1, 4'hE, 4'h7, 1, 4'd1, 32'd5,        32'd3,        1, 1, 32'hFFFFFFFE, 4'b1000);
        issue(1, 4'hE, 4'h6, 0, 4'd1, 32'd10,       32'd3,        1, 1, 32'h00000006, 4'b1000);
        issue(1, 4'hE, 4'hE, 1, 4'd1, 32'hFF,       32'h0F,       1, 1, 32'h000000F0, 4'b0000);
        issue(1, 4'hE, 4'hF, 1, 4'd1, 32'd0,        32'd0,        1, 1, 32'hFFFFFFFF, 4'b1000);
        issue(1, 4'hA, 4'h4, 1, 4'd1, 32'd1,        32'd1,        0, 0, 32'h00000002, 4'b1000);
        issue(1, 4'hB, 4'hC, 1, 4'd1, 32'd0,        32'd0,        1, 1, 32'h00000000, 4'b0100);
        issue(1, 4'hE, 4'h3, 1, 4'd1, 32'd1,        32'd0,        1, 1, 32'hFFFFFFFF, 4'b1000);
        issue(1, 4'hE, 4'h8, 0, 4'd1, 32'h80000000, 32'h80000000, 1, 0, 32'h80000000, 4'b1000);
        issue(1, 4'hE, 4'h9, 0, 4'd1, 32'd5,        32'd5,        1, 0, 32'h00000000, 4'b0100);
        issue(1, 4'hE, 4'h2, 1, 4'd7, 32'h80000000, 32'd1,        1, 1, 32'h7FFFFFFF, 4'b0011);

        // Backpressure: pending HI AND must wait while the SUB result is held
        wb_ready = 1'b0;
        dp_dt = 1'b1; cond = 4'h8; mf_op = {1'b0, 4'h0, 1'b1}; reg_d = 4'd8;
        operand_1 = 32'hFF; operand_2 = 32'h0F; in_valid = 1'b1;
        sb.push_back({1'b1, 4'd8, 32'h0000000F, 4'b0011});
        exp_exec++;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall_in_ready", 32'(in_ready), 32'd0);
            check("stall_wb_data", wb_data, 32'h7FFFFFFF);
            check("stall_flags", 32'(flags), 32'(4'b0011));
            @(posedge clk);
        end
        #1 wb_ready = 1'b1;
        @(negedge clk);
        check("release_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        check("release_accept", wb_data, 32'h0000000F);

        // Reset while a slot is stalled
        @(posedge clk);
        #1 wb_ready = 1'b0;
        issue(1, 4'hE, 4'hF, 1, 4'd9, 32'd0, 32'd0, 1, 1, 32'hFFFFFFFF, 4'b1011);
        rst_n = 1'b0;
        sb.delete();
        @(posedge clk);
        #1;
        @(negedge clk);
        check("rst2_wb_valid", 32'(wb_valid), 32'd0);
        check("rst2_wb_en", 32'(wb_en), 32'd0);
        check("rst2_wb_addr", 32'(wb_addr), 32'd0);
        check("rst2_wb_data", wb_data, 32'd0);
        check("rst2_flags", 32'(flags), 32'd0);
        check("rst2_cnt_exec", 32'(cnt_exec), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1; wb_ready = 1'b1;
        exp_exec = 0;
        exp_skip = 0;

        issue(1, 4'h0, 4'h4, 0, 4'd1, 32'd1,   32'd1,   0, 0, 32'h00000002, 4'b0000);
        issue(1, 4'hE, 4'h4, 1, 4'd1, 32'd1,   32'd2,   1, 1, 32'h00000003, 4'b0000);
        issue(1, 4'hE, 4'hD, 1, 4'd1, 32'd9,   32'd0,   1, 1, 32'h00000000, 4'b0100);
        issue(1, 4'h1, 4'h4, 0, 4'd1, 32'd1,   32'd1,   0, 0, 32'h00000002, 4'b0100);
        issue(1, 4'h0, 4'hC, 1, 4'd1, 32'h10,  32'h01,  1, 1, 32'h00000011, 4'b0000);
        issue(0, 4'hE, 4'h4, 1, 4'd1, 32'd3,   32'd4,   1, 0, 32'h00000007, 4'b0000);
        issue(1, 4'hE, 4'hA, 1, 4'd1, 32'd1,   32'd2,   1, 0, 32'hFFFFFFFF, 4'b1000);

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("sb_drained", 32'(sb.size()), 32'd0);
        check("idle_wb_valid", 32'(wb_valid), 32'd0);
`ifdef EXEC_PERF_CNT_EN
        check("cnt_exec", 32'(cnt_exec), 32'(exp_exec));
        check("cnt_skip", 32'(cnt_skip), 32'(exp_skip));
`else
        check("cnt_exec_off", 32'(cnt_exec), 32'd0);
        check("cnt_skip_off", 32'(cnt_skip), 32'd0);
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running expected=finished");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "timeout");
    end
endmodule
